// File: rtl/dm_stall_mem.sv
// rtl/dm_stall_mem.sv - latency-configurable data memory slave with byte-enable writes and a write-log FIFO
module dm_stall_mem #(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned LATENCY     = 2,
    parameter int unsigned LOG_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_byteen,
    input  logic [31:0] req_pc,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic        log_valid,
    input  logic        log_ready,
    output logic [31:0] log_pc,
    output logic [31:0] log_addr,
    output logic [31:0] log_data
);
    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int PTR_W = (LOG_DEPTH > 1) ? $clog2(LOG_DEPTH) : 1;
    localparam logic [31:0]    DEPTH_L  = 32'(DEPTH_WORDS);
    localparam logic [3:0]     LAT_L    = 4'(LATENCY);
    localparam logic [PTR_W:0] LOG_FULL = (PTR_W + 1)'(LOG_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t state, state_n;
    logic [3:0] cnt, cnt_n;

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0]      offset;
    logic [29:0]      word_off;
    logic [IDX_W-1:0] idx;
    logic             out_of_range;
    logic             is_write;
    logic             accept;
    logic [31:0]      old_word;
    logic [31:0]      merged;
    logic [31:0]      rdata_q;
    logic             err_q;
    logic             unused_offset_lsbs;

    logic [31:0]      fifo_pc   [LOG_DEPTH];
    logic [31:0]      fifo_addr [LOG_DEPTH];
    logic [31:0]      fifo_data [LOG_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             fifo_full;
    logic             push, pop;

    // Address decode: the subtraction wraps for addresses below BASE_ADDR, so that case is checked separately.
    assign offset             = req_addr - BASE_ADDR;
    assign word_off           = offset[31:2];
    assign idx                = word_off[IDX_W-1:0];
    assign out_of_range       = (req_addr < BASE_ADDR) || ({2'b00, word_off} >= DEPTH_L);
    assign unused_offset_lsbs = ^offset[1:0];
    assign is_write           = (req_byteen != 4'b0000);
    assign old_word           = mem[idx];

    // A read has no lanes enabled, so merged doubles as the read word.
    always_comb begin
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (req_byteen[i]) merged[8*i +: 8] = req_wdata[8*i +: 8];
        end
    end

    assign fifo_full = (count == LOG_FULL);
    assign req_ready = !reset && (state == ST_IDLE || state == ST_RESP) && !fifo_full;
    assign accept    = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            ST_IDLE, ST_RESP: begin
                if (accept) begin
                    if (LATENCY == 0) begin
                        state_n = ST_RESP;
                    end else begin
                        state_n = ST_WAIT;
                        cnt_n   = LAT_L;
                    end
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_WAIT: begin
                cnt_n = cnt - 4'd1;
                if (cnt == 4'd1) state_n = ST_RESP;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign rsp_valid = (state == ST_RESP);
    assign rsp_rdata = rsp_valid ? rdata_q : 32'd0;
    assign rsp_err   = rsp_valid && err_q;
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH_WORDS); i++) mem[IDX_W'(i)] <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else if (accept) begin
            if (out_of_range) begin
                rdata_q <= 32'd0;
                err_q   <= 1'b1;
            end else begin
                rdata_q <= merged;
                err_q   <= 1'b0;
                if (is_write) mem[idx] <= merged;
            end
        end
    end

    // Write log: every committed in-range write, in acceptance order.
    assign push      = accept && is_write && !out_of_range;
    assign log_valid = (count != '0);
    assign pop       = log_valid && log_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(LOG_DEPTH); i++) begin
                fifo_pc[PTR_W'(i)]   <= 32'd0;
                fifo_addr[PTR_W'(i)] <= 32'd0;
                fifo_data[PTR_W'(i)] <= 32'd0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_pc[wr_ptr]   <= req_pc;
                fifo_addr[wr_ptr] <= {req_addr[31:2], 2'b00};
                fifo_data[wr_ptr] <= merged;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign log_pc   = fifo_pc[rd_ptr];
    assign log_addr = fifo_addr[rd_ptr];
    assign log_data = fifo_data[rd_ptr];

endmodule

// File: doc/dm_stall_mem.md
Name: dm_stall_mem

Overview:
- Parametrised data-memory slave for the pipelined MIPS core. Supports byte-enable writes, configurable access latency through a valid/ready request handshake, and a one-cycle response strobe.
- Every committed write is pushed into a write-log FIFO for trace comparison.
- Replaces the zero-latency combinational data array, so the core's stall logic can be exercised against multi-cycle memory.

Parameters:
- DEPTH_WORDS, 4096, number of 32-bit words in the array; power of two.
- BASE_ADDR, 32'h0000_0000, byte address of word 0.
- LATENCY, 2, wait cycles between acceptance and response; legal range 0..15.
- LOG_DEPTH, 8, write-log FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  sole clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  slave can accept this cycle.
- req_addr  in  32  byte address; bits [1:0] ignored (word-aligned).
- req_wdata  in  32  write data, lane-aligned.
- req_byteen  in  4  lane enables; 4'b0000 = read, otherwise write.
- req_pc  in  32  PC of the issuing instruction, carried to the log.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  32  read word, or merged word for a write.
- rsp_err  out  1  address out of range; valid with rsp_valid.
- busy  out  1  transaction in flight (state != IDLE).
- log_valid  out  1  FIFO non-empty.
- log_ready  in  1  consumer pops the head when log_valid is high.
- log_pc  out  32  head entry: PC.
- log_addr  out  32  head entry: word-aligned byte address.
- log_data  out  32  head entry: full merged word after the write.

Behaviour:
- Reset (sync): state=IDLE; wait counter=0; all array words=0; FIFO emptied.
  - Output values: rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, log_valid=0, log_* =0.
  - req_ready=0 during the reset cycle.
  - Reset mid-transaction drops the pending response silently.
- Index calculation: idx=(req_addr-BASE_ADDR)>>2. The request is out of range if req_addr<BASE_ADDR or idx>=DEPTH_WORDS.
- FSM has three states: IDLE, WAIT, RESP.
- req_ready is high when all of the following hold: not reset; state is IDLE or RESP; FIFO not full.
  - The full condition applies to reads as well, which keeps ordering simple.
- Acceptance happens on an edge where req_valid&&req_ready. At that edge:
  - Write, in range: merged = old word with each lane i replaced by req_wdata lane i where req_byteen[i]. Array[idx] <= merged. Push {req_pc, aligned addr, merged} into the FIFO.
  - Read, in range: capture array[idx]. The value reflects all previously accepted writes.
  - Out of range: no array write, no log push; response data=0, err=1.
  - Response data and err are latched internally.
  - Next state: RESP if LATENCY==0; otherwise WAIT with counter=LATENCY.
- WAIT: counter decrements every cycle. When counter==1, the next state is RESP.
- RESP, one cycle only:
  - rsp_valid=1; rsp_rdata and rsp_err come from the latched values.
  - If a new request is accepted this cycle, the FSM behaves as from IDLE (back-to-back). Otherwise it returns to IDLE.
  - Outside RESP, rsp_valid=0 and rsp_rdata/rsp_err hold 0.
- Latency: the response cycle is exactly LATENCY+1 cycles after the acceptance cycle. Maximum throughput is one request per LATENCY+1 cycles.
- FIFO behaviour:
  - Pop on log_valid&&log_ready.
  - A simultaneous push and pop on a non-empty FIFO keeps the count unchanged.
  - A pop on an empty FIFO is ignored.
  - Pointers wrap modulo LOG_DEPTH.
  - log_* show the head entry combinationally from registered storage.
- Request inputs are sampled only at acceptance. Changes while req_ready=0 have no effect.

Test Plan:
- Reset, then write addr 0x10, byteen 4'hF, wdata 0x12345678, pc 0x3000, LATENCY=2 -> req_ready drops for 2 cycles; rsp_valid in cycle 3 after acceptance with rdata 0x12345678, err=0; log head {0x3000, 0x10, 0x12345678}.
- Byte merge: write 0x12345678 to 0x10, then byteen 4'b0010 with wdata 0x0000AB00 to 0x11 -> merged 0x1234AB78; a subsequent read of 0x10 returns 0x1234AB78.
- Out of range, DEPTH_WORDS=4096: write to 0x4000 -> rsp_err=1, rdata=0, no log push; a following read of 0x0 returns 0.
- LATENCY=0 back-to-back: 4 reads held valid continuously -> rsp_valid high on 4 consecutive cycles, each the cycle after its acceptance.
- Log backpressure, LOG_DEPTH=2, log_ready=0: 3 writes -> third stalls with req_ready=0. Pulse log_ready one cycle -> first entry popped, third write accepted next; FIFO order preserved.
- Reset asserted during WAIT -> no rsp_valid; array reads 0; log_valid=0 after reset.
